// File: rtl/dino_pkg.sv
// Shared types and constants for the dinosaur-runner obstacle pipeline.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CRASH = 2'd2
  } state_e;

  localparam int TICK_DIV_DEF = 250000;
  localparam int SCREEN_W_DEF = 160;
  localparam int DINO_X_DEF   = 16;
  localparam int DINO_W_DEF   = 8;
  localparam int OBST_H_DEF   = 12;
  localparam int MIN_GAP_DEF  = 40;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register uses bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_DIGITS  = 4;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bcd_score_counter.sv
// Four-digit BCD up-counter that saturates at 9999; clear has priority over increment.
module bcd_score_counter
  import dino_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] score_bcd
);

  logic [15:0] score_q, score_d;
  logic        carry_s;
  logic [BCD_DIGIT_W-1:0] digit_s;

  // Ripple a +1 through the decimal digits unless already at the ceiling
  always_comb begin
    score_d = score_q;
    carry_s = 1'b0;
    digit_s = {BCD_DIGIT_W{1'b0}};
    if (clr) begin
      score_d = 16'h0000;
    end else if (inc && (score_q != 16'h9999)) begin
      carry_s = 1'b1;
      for (int i = 0; i < BCD_DIGITS; i++) begin
        digit_s = score_q[i*BCD_DIGIT_W +: BCD_DIGIT_W];
        if (carry_s && (digit_s == 4'd9)) begin
          score_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd0;
          carry_s = 1'b1;
        end else if (carry_s) begin
          score_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] = digit_s + 4'd1;
          carry_s = 1'b0;
        end else begin
          score_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] = digit_s;
        end
      end
    end else begin
      score_d = score_q;
    end
  end

  // Score register
  always_ff @(posedge clk) begin
    if (rst) begin
      score_q <= 16'h0000;
    end else begin
      score_q <= score_d;
    end
  end

  assign score_bcd = score_q;

endmodule

// File: rtl/obstacle_track.sv
// Two-slot scrolling obstacle track: prescaled scroll, LFSR-spaced spawns,
// collision detection against the dinosaur and a BCD count of cleared obstacles.
module obstacle_track
  import dino_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int DINO_X   = DINO_X_DEF,
  parameter int DINO_W   = DINO_W_DEF,
  parameter int OBST_H   = OBST_H_DEF,
  parameter int MIN_GAP  = MIN_GAP_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        game_status,
  input  logic [5:0]  dinosaur_height,
  output logic [1:0]  obs_valid,
  output logic [7:0]  obs_x0,
  output logic [7:0]  obs_x1,
  output logic [15:0] score_bcd,
  output logic        crash,
  output logic        scroll_tick
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  state_e            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic              tick_q, tick_d;
  logic              crash_q, crash_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [7:0]        gap_q, gap_d;
  logic [7:0]        next_gap_q, next_gap_d;
  logic [1:0]        valid_q, valid_d;
  logic [1:0][7:0]   x_q, x_d;

  logic              presc_wrap_s, hit_s, do_tick_s;
  logic              score_inc_s, score_clr_s;
  logic [7:0]        gap_inc_s;

  assign presc_wrap_s = (presc_q == PW'(TICK_DIV - 1));

  // Hit check runs every clock against the current slot positions
  always_comb begin
    hit_s = 1'b0;
    for (int n = 0; n < 2; n++) begin
      if (valid_q[n] && (x_q[n] >= 8'(DINO_X)) && (x_q[n] <= 8'(DINO_X + DINO_W - 1))
          && (dinosaur_height < 6'(OBST_H))) begin
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Next-state, scroll, spawn and score control
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_next(lfsr_q);
    valid_d     = valid_q;
    x_d         = x_q;
    gap_d       = gap_q;
    next_gap_d  = next_gap_q;
    do_tick_s   = 1'b0;
    score_inc_s = 1'b0;
    score_clr_s = 1'b0;
    gap_inc_s   = (gap_q == 8'hFF) ? gap_q : gap_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (game_status) begin
          state_d     = RUN;
          score_clr_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!game_status) begin
          state_d = IDLE;
        end else if (hit_s) begin
          state_d = CRASH;
        end else begin
          state_d   = RUN;
          do_tick_s = presc_wrap_s;
        end
      end
      CRASH: begin
        if (!game_status) begin
          state_d = IDLE;
        end else begin
          state_d = CRASH;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_tick_s) begin
      for (int n = 0; n < 2; n++) begin
        if (valid_q[n] && (x_q[n] == 8'd0)) begin
          valid_d[n]  = 1'b0;
          score_inc_s = 1'b1;
        end else if (valid_q[n]) begin
          x_d[n] = x_q[n] - 8'd1;
        end else begin
          x_d[n] = x_q[n];
        end
      end
      // Free slots come from the pre-tick flags, so a slot vacated now waits a tick
      if ((gap_inc_s >= next_gap_q) && !valid_q[0]) begin
        valid_d[0] = 1'b1;
        x_d[0]     = 8'(SCREEN_W - 1);
        gap_d      = 8'd0;
        next_gap_d = 8'(MIN_GAP) + {2'b00, lfsr_q[5:0]};
      end else if ((gap_inc_s >= next_gap_q) && !valid_q[1]) begin
        valid_d[1] = 1'b1;
        x_d[1]     = 8'(SCREEN_W - 1);
        gap_d      = 8'd0;
        next_gap_d = 8'(MIN_GAP) + {2'b00, lfsr_q[5:0]};
      end else begin
        gap_d = gap_inc_s;
      end
    end else begin
      gap_d = gap_q;
    end

    if (state_d == IDLE) begin
      valid_d    = 2'b00;
      x_d        = {2{8'h00}};
      gap_d      = 8'd0;
      next_gap_d = 8'(MIN_GAP);
    end else begin
      valid_d = valid_d;
    end
  end

  assign presc_d = ((state_q == RUN) && (state_d == RUN))
                 ? (presc_wrap_s ? {PW{1'b0}} : presc_q + PW'(1))
                 : {PW{1'b0}};
  assign tick_d  = (state_d == RUN) && (presc_d == PW'(TICK_DIV - 1));
  assign crash_d = (state_d == CRASH);

  // State registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      presc_q    <= {PW{1'b0}};
      tick_q     <= 1'b0;
      crash_q    <= 1'b0;
      lfsr_q     <= LFSR_SEED;
      gap_q      <= 8'd0;
      next_gap_q <= 8'(MIN_GAP);
      valid_q    <= 2'b00;
      x_q        <= {2{8'h00}};
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      crash_q    <= crash_d;
      lfsr_q     <= lfsr_d;
      gap_q      <= gap_d;
      next_gap_q <= next_gap_d;
      valid_q    <= valid_d;
      x_q        <= x_d;
    end
  end

  bcd_score_counter u_score (
    .clk       (CLK),
    .rst       (RST),
    .inc       (score_inc_s),
    .clr       (score_clr_s),
    .score_bcd (score_bcd)
  );

  assign obs_valid   = valid_q;
  assign obs_x0      = x_q[0];
  assign obs_x1      = x_q[1];
  assign crash       = crash_q;
  assign scroll_tick = tick_q;

endmodule

// File: doc/obstacle_track.md
OBSTACLE_TRACK -- requirements
Module: obstacle_track

Interface
REQ-001 Parameter TICK_DIV, default 250000, clocks per scroll tick (must be >= 2).
REQ-002 Parameter SCREEN_W, default 160, playfield width in columns; spawn column is SCREEN_W-1.
REQ-003 Parameter DINO_X, default 16, leftmost dinosaur column.
REQ-004 Parameter DINO_W, default 8, dinosaur width in columns.
REQ-005 Parameter OBST_H, default 12, obstacle height; dinosaur clears it when dinosaur_height >= OBST_H.
REQ-006 Parameter MIN_GAP, default 40, minimum ticks between spawns.
REQ-007 Single clock, single reset: CLK in 1, rising-edge clock; RST in 1, synchronous, active-high reset.
REQ-008 game_status in 1, running flag from the jump stage; 1 = game running.
REQ-009 dinosaur_height in 6, current dinosaur height from the jump stage; 0 = ground.
REQ-010 obs_valid out 2, slot occupancy flags; bit n is slot n.
REQ-011 obs_x0 out 8, slot-0 column; obs_x1 out 8, slot-1 column; both meaningful only when the matching valid bit is 1.
REQ-012 score_bcd out 16, 4-digit BCD count of cleared obstacles.
REQ-013 crash out 1, level output, high while in CRASH.
REQ-014 scroll_tick out 1, one-cycle pulse on each scroll tick.

Function
REQ-015 FSM states and transitions: IDLE -> RUN when game_status=1; RUN -> CRASH on registered collision; RUN -> IDLE when game_status=0; CRASH -> IDLE when game_status=0.
REQ-016 Prescaler counts 0..TICK_DIV-1 in RUN only; scroll_tick=1 for exactly the cycle the count equals TICK_DIV-1, then the count wraps to 0; count is held at 0 in IDLE and CRASH.
REQ-017 On each tick, every valid slot with x>0 decrements x by 1; a valid slot with x=0 becomes invalid and score increments by 1.
REQ-018 Score increments BCD-correctly (0009->0010, 0099->0100), saturates at 9999, clears to 0 on IDLE->RUN, and holds through CRASH and IDLE.
REQ-019 LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, seed 8'hA5, advances every clock in all states.
REQ-020 gap_cnt increments on every tick in RUN, saturating at 8'hFF.
REQ-021 When gap_cnt >= next_gap on a tick: spawn into the lowest-index free slot at x=SCREEN_W-1, set gap_cnt=0, and latch next_gap=MIN_GAP+lfsr[5:0].
REQ-022 If no slot is free at spawn time, no spawn occurs and gap_cnt keeps counting; the spawn retries on the next tick.
REQ-023 A slot that frees on a tick is not reusable until the following tick.
REQ-024 A slot hits when valid, DINO_X <= x <= DINO_X+DINO_W-1 and dinosaur_height < OBST_H, evaluated every clock, not only on ticks.
REQ-025 Any hit in RUN moves the FSM to CRASH next cycle; crash=1 from that cycle.
REQ-026 When a hit and a tick coincide, the collision wins: no scroll, no spawn, no score change that cycle.
REQ-027 In CRASH, slots, positions and score are frozen for display.
REQ-028 On entry to IDLE: both valid bits clear, gap_cnt=0, next_gap=MIN_GAP.
REQ-029 In IDLE, obstacle state stays cleared.

Reset
REQ-030 RST=1 at a clock edge forces IDLE, prescaler=0, gap_cnt=0, next_gap=MIN_GAP, lfsr=8'hA5, obs_valid=0, obs_x0=obs_x1=0, score_bcd=0, crash=0, scroll_tick=0.
REQ-031 RST asserted mid-RUN or mid-CRASH overrides all other events in that cycle.

Structure
REQ-032 Shared package dino_pkg holds: the FSM state enum (IDLE, RUN, CRASH), the screen-geometry defaults, LFSR seed and taps, and the BCD digit width.
REQ-033 One sub-module, bcd_score_counter (inputs inc and clr; 16-bit saturating BCD output), is instantiated once.
REQ-034 All other logic is flat in obstacle_track.

Verification (TICK_DIV=4, MIN_GAP=2, SCREEN_W=160)
REQ-035 Reset then game_status=1: scroll_tick on cycles 4, 8, 12...; first spawn at x=159 on tick 2, obs_valid=01.
REQ-036 Hold dinosaur_height=20 for the whole game: slot reaches x=0, vanishes on the next tick, score_bcd=0001, crash stays 0.
REQ-037 dinosaur_height=0 when a slot reaches x=23: crash=1 one cycle later; positions and score are frozen.
REQ-038 Preload score 0099 and clear an obstacle: score_bcd=0100. Preload 9999: score remains 9999.
REQ-039 Hit and scroll_tick in the same cycle: x is unchanged and crash=1. Then game_status=0: IDLE with obs_valid=00; game_status=1 again: score_bcd=0000.
REQ-040 RST pulse mid-RUN with both slots valid: next cycle all outputs match the REQ-030 reset values.
